// File: rtl/load_store_unit_if.sv
// Load/store unit bus: CPU request side plus word-only memory side.
// slave = the LSU, master = the CPU/memory environment driving it.
interface load_store_unit_if #(
  parameter int ADDR_WIDTH = 32
);
  logic                  Req;
  logic                  IsStore;
  logic [1:0]            Size;
  logic                  Unsigned;
  logic [ADDR_WIDTH-1:0] Address;
  logic [31:0]           WriteData;
  logic                  Busy;
  logic                  Done;
  logic                  Misaligned;
  logic [31:0]           LoadData;
  logic [ADDR_WIDTH-1:0] MemAddress;
  logic [31:0]           MemWriteData;
  logic                  MemWrite;
  logic                  MemRead;
  logic [31:0]           MemReadData;

  modport slave (
    input  Req, IsStore, Size, Unsigned,
    input  Address, WriteData, MemReadData,
    output Busy, Done, Misaligned, LoadData,
    output MemAddress, MemWriteData,
    output MemWrite, MemRead
  );

  modport master (
    output Req, IsStore, Size, Unsigned,
    output Address, WriteData, MemReadData,
    input  Busy, Done, Misaligned, LoadData,
    input  MemAddress, MemWriteData,
    input  MemWrite, MemRead
  );
endinterface

// File: rtl/load_store_unit.sv
// Load/store sequencer for a word-only memory: RMW sub-word stores,
// sign/zero-extended loads. Ports: clk, rst (async high), bus (slave).
module load_store_unit #(
  parameter int ADDR_WIDTH = 32
) (
  input logic               clk,
  input logic               rst,
  load_store_unit_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE,
    READ,
    WRITE,
    DONE
  } state_t;

  state_t state;
  state_t nextState;

  logic                  rIsStore;
  logic                  rUnsigned;
  logic [1:0]            rSize;
  logic [1:0]            rLane;
  logic                  rMis;
  logic [ADDR_WIDTH-1:0] memAddr;
  logic [31:0]           memWdata;
  logic [31:0]           loadReg;

  logic        reqMis;
  logic [31:0] shifted;
  logic [7:0]  byteSel;
  logic [15:0] halfSel;
  logic [31:0] loadExt;
  logic [31:0] merged;

  always_comb begin
    reqMis = 1'b1;
    unique case (bus.Size)
      2'b00:   reqMis = 1'b0;
      2'b01:   reqMis = bus.Address[0];
      2'b10:   reqMis = |bus.Address[1:0];
      default: reqMis = 1'b1;
    endcase
  end

  always_comb begin
    nextState = state;
    unique case (state)
      IDLE: begin
        if (bus.Req) begin
          if (reqMis)
            nextState = DONE;
          else if (bus.IsStore && bus.Size == 2'b10)
            nextState = WRITE;
          else
            nextState = READ;
        end
      end
      READ:  nextState = rIsStore ? WRITE : DONE;
      WRITE: nextState = DONE;
      DONE:  nextState = IDLE;
    endcase
  end

  // Lane select and extension of the word read from memory.
  always_comb begin
    shifted = bus.MemReadData >> {rLane, 3'b000};
    byteSel = shifted[7:0];
    halfSel = rLane[1] ? bus.MemReadData[31:16]
                       : bus.MemReadData[15:0];
    loadExt = bus.MemReadData;
    if (rSize == 2'b00)
      loadExt = {{24{~rUnsigned & byteSel[7]}}, byteSel};
    else if (rSize == 2'b01)
      loadExt = {{16{~rUnsigned & halfSel[15]}}, halfSel};
  end

  // memWdata still holds the captured store data while in READ.
  always_comb begin
    merged = bus.MemReadData;
    if (rSize == 2'b00) begin
      unique case (rLane)
        2'd0: merged[7:0]   = memWdata[7:0];
        2'd1: merged[15:8]  = memWdata[7:0];
        2'd2: merged[23:16] = memWdata[7:0];
        2'd3: merged[31:24] = memWdata[7:0];
      endcase
    end else if (rLane[1]) begin
      merged[31:16] = memWdata[15:0];
    end else begin
      merged[15:0] = memWdata[15:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      rIsStore  <= 1'b0;
      rUnsigned <= 1'b0;
      rSize     <= 2'b00;
      rLane     <= 2'b00;
      rMis      <= 1'b0;
      memAddr   <= '0;
      memWdata  <= '0;
      loadReg   <= '0;
    end else begin
      state <= nextState;
      if (state == IDLE && bus.Req) begin
        rIsStore  <= bus.IsStore;
        rUnsigned <= bus.Unsigned;
        rSize     <= bus.Size;
        rLane     <= bus.Address[1:0];
        rMis      <= reqMis;
        memAddr   <= {bus.Address[ADDR_WIDTH-1:2], 2'b00};
        if (bus.IsStore)
          memWdata <= bus.WriteData;
      end
      if (state == READ) begin
        if (rIsStore)
          memWdata <= merged;
        else
          loadReg <= loadExt;
      end
    end
  end

  assign bus.Busy         = (state != IDLE);
  assign bus.Done         = (state == DONE);
  assign bus.Misaligned   = (state == DONE) && rMis;
  assign bus.MemRead      = (state == READ);
  assign bus.MemWrite     = (state == WRITE);
  assign bus.MemAddress   = memAddr;
  assign bus.MemWriteData = memWdata;
  assign bus.LoadData     = loadReg;

endmodule
